uart_rx_unit: RTL and testbench

//  Serial receive front end for the MIPS pipeline debug/load link: a mod-M baud tick generator
//  (baud_rate_gen) plus an oversampling 8N1 UART receiver (uart_rx) in one block.

---
 rtl/uart_rx_unit.sv | 140 ++++++++++++++
 tb/tb_uart_rx_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_unit.sv
// Serial receive front end: mod-M baud tick generator plus 16x oversampling 8N1 receiver.
// Optional build macro UART_RX_SYNC_EN adds a 2-flop synchroniser on rx before the FSM.
module uart_rx_unit #(
  parameter int unsigned NB      = 8,
  parameter int unsigned M       = 2,
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  output logic          s_tick,
  output logic [NB-1:0] q,
  output logic          rx_done_tick,
  output logic [7:0]    dout
);

  localparam int unsigned SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [NB-1:0] cnt_q, cnt_d;
  logic          rx_in;
  state_e        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [NW-1:0] n_q, n_d;
  logic [7:0]    b_q, b_d;
  logic [7:0]    dout_q;
  logic          done;

  // Baud tick generator
  assign cnt_d  = (cnt_q == NB'(M - 1)) ? '0 : cnt_q + NB'(1);
  assign s_tick = (cnt_q == NB'(M - 1));
  assign q      = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rx_in = sync_q[1];
`else
  assign rx_in = rx;
`endif

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_in) begin
          state_d = StStart;
          s_d     = '0;
        end
      end
      StStart: begin
        if (s_tick) begin
          // Mid start bit: a high line here means the falling edge was a glitch
          if (s_q == SW'(7)) begin
            if (!rx_in) begin
              state_d = StData;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      StData: begin
        if (s_tick) begin
          if (s_q == SW'(15)) begin
            s_d = '0;
            b_d = {rx_in, b_q[7:1]};
            if (n_q == NW'(DBIT - 1)) begin
              state_d = StStop;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      StStop: begin
        if (s_tick) begin
          if (s_q == SW'(SB_TICK - 1)) begin
            state_d = StIdle;
            done    = 1'b1;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      if (done) begin
        dout_q <= b_q;
      end
    end
  end

  // The completed byte is forwarded during the strobe cycle so dout is valid with rx_done_tick
  assign rx_done_tick = done & ~reset;
  assign dout         = rx_done_tick ? b_q : dout_q;

endmodule

// File: tb/tb_uart_rx_unit.sv
// Directed self-checking bench for uart_rx_unit (M=2, 10 ns clock, 16 s_ticks per bit).
`timescale 1ns / 1ps
module tb_uart_rx_unit;

  localparam int unsigned BIT_NS = 320;

  logic       clk;
  logic       reset;
  logic       rx;
  logic       s_tick;
  logic [7:0] q;
  logic       rx_done_tick;
  logic [7:0] dout;

  int total;
  int bad;
  int strobes;
  int wide;
  int holdbad;
  logic [7:0] got [0:15];
  logic       prev_done;
  logic [7:0] prev_dout;

  uart_rx_unit #(
    .NB      (8),
    .M       (2),
    .DBIT    (8),
    .SB_TICK (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .q            (q),
    .rx_done_tick (rx_done_tick),
    .dout         (dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    strobes   = 0;
    wide      = 0;
    holdbad   = 0;
    prev_done = 1'b0;
    prev_dout = 8'h00;
  end

  // Strobe capture and dout-hold watch, sampled on the falling edge
  always @(negedge clk) begin
    if (rx_done_tick === 1'b1) begin
      if (strobes < 16) got[strobes] = dout;
      strobes = strobes + 1;
      if (prev_done === 1'b1) wide = wide + 1;
    end
    if (reset === 1'b0 && rx_done_tick !== 1'b1 && dout !== prev_dout) holdbad = holdbad + 1;
    prev_done = rx_done_tick;
    prev_dout = dout;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] data, input int nbits);
    logic [9:0] frame;
    frame = {1'b1, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx = frame[i];
      #(BIT_NS);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    rx    = 1'b1;

    repeat (9) @(negedge clk);
    check("reset_q", 32'(q), 32'h0);
    check("reset_s_tick", 32'(s_tick), 32'h0);
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_done", 32'(rx_done_tick), 32'h0);
    reset = 1'b0;

    // q runs 1,0,1,0...; s_tick high exactly when q==1
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("tick_q", 32'(q), (i % 2 == 0) ? 32'h1 : 32'h0);
      check("tick_s", 32'(s_tick), (i % 2 == 0) ? 32'h1 : 32'h0);
    end

    send_bits(8'h02, 10);
    #100;
    check("b02_count", 32'(strobes), 32'd1);
    check("b02_byte", 32'(got[0]), 32'h02);
    check("b02_dout", 32'(dout), 32'h02);

    #10000;
    check("idle_hold", 32'(dout), 32'h02);
    send_bits(8'h3C, 10);
    #100;
    check("b3c_count", 32'(strobes), 32'd2);
    check("b3c_byte", 32'(got[1]), 32'h3C);
    check("b3c_dout", 32'(dout), 32'h3C);

    // 4 s_ticks low = 8 clk
    rx = 1'b0;
    #80;
    rx = 1'b1;
    #(2 * BIT_NS);
    check("glitch_count", 32'(strobes), 32'd2);
    check("glitch_dout", 32'(dout), 32'h3C);

    // Start bit and three data bits of 0xA5, then reset mid DATA
    send_bits(8'hA5, 4);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    rx    = 1'b1;
    reset = 1'b0;
    #(2 * BIT_NS);
    check("abort_count", 32'(strobes), 32'd2);
    check("abort_dout", 32'(dout), 32'h00);
    check("abort_done", 32'(rx_done_tick), 32'h0);

    send_bits(8'h5A, 10);
    #100;
    check("b5a_count", 32'(strobes), 32'd3);
    check("b5a_byte", 32'(got[2]), 32'h5A);
    check("b5a_dout", 32'(dout), 32'h5A);

    send_bits(8'hFF, 10);
    send_bits(8'h00, 10);
    #100;
    check("b2b_count", 32'(strobes), 32'd5);
    check("b2b_first", 32'(got[3]), 32'hFF);
    check("b2b_second", 32'(got[4]), 32'h00);
    check("b2b_dout", 32'(dout), 32'h00);

    check("strobe_width", 32'(wide), 32'd0);
    check("dout_hold", 32'(holdbad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
